// File: rtl/sum_of_three.sv
// sum_of_three: sums three unsigned samples into a registered DWIDTH result.
// Define SUM3_SLIDING_EN for a sliding window; the default is non-overlapping blocks of three.
module sum_of_three #(
  parameter int DWIDTH = 8,
  parameter int IWIDTH = DWIDTH - 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IWIDTH-1:0] i_n,
  input  logic              i_n_valid,
  input  logic              i_clear,
  output logic [DWIDTH-1:0] o_sum,
  output logic              o_sum_valid,
  output logic [1:0]        o_fill
);
  typedef enum logic [1:0] {FILL0 = 2'd0, FILL1 = 2'd1, FILL2 = 2'd2} fill_t;
  fill_t             state_q, state_d;
  logic [DWIDTH-1:0] sum_q, sum_d;
  logic              sum_valid_q, sum_valid_d;
  logic [DWIDTH-1:0] n_ext;
  assign n_ext = DWIDTH'(i_n);
`ifdef SUM3_SLIDING_EN
  // h1 is the newest held sample, h2 the one before it
  logic [IWIDTH-1:0] h1_q, h1_d, h2_q, h2_d;
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    sum_valid_d = 1'b0;
    h1_d        = h1_q;
    h2_d        = h2_q;
    if (i_clear) begin
      state_d = FILL0;
      h1_d    = '0;
      h2_d    = '0;
    end else if (i_n_valid) begin
      h1_d    = i_n;
      h2_d    = h1_q;
      state_d = (state_q == FILL0) ? FILL1 : FILL2;
      if (state_q == FILL2) begin
        sum_d       = n_ext + DWIDTH'(h1_q) + DWIDTH'(h2_q);
        sum_valid_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1_q <= '0;
      h2_q <= '0;
    end else begin
      h1_q <= h1_d;
      h2_q <= h2_d;
    end
  end
`else
  logic [DWIDTH-1:0] acc_q, acc_d;
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    sum_valid_d = 1'b0;
    acc_d       = acc_q;
    if (i_clear) begin
      state_d = FILL0;
      acc_d   = '0;
    end else if (i_n_valid) begin
      if (state_q == FILL2) begin
        sum_d       = acc_q + n_ext;
        sum_valid_d = 1'b1;
        acc_d       = '0;
        state_d     = FILL0;
      end else begin
        acc_d   = (state_q == FILL0) ? n_ext : acc_q + n_ext;
        state_d = (state_q == FILL0) ? FILL1 : FILL2;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else acc_q <= acc_d;
  end
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
    end
  end
  assign o_sum       = sum_q;
  assign o_sum_valid = sum_valid_q;
  assign o_fill      = state_q;
endmodule

// File: tb/tb_sum_of_three.sv
// tb_sum_of_three: directed and random stimulus against a queue-based window model with a scoreboard monitor.
module tb_sum_of_three;
  localparam int DWIDTH = 8;
  localparam int IWIDTH = 6;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [IWIDTH-1:0] i_n = '0;
  logic              i_n_valid = 1'b0;
  logic              i_clear = 1'b0;
  logic [DWIDTH-1:0] o_sum;
  logic              o_sum_valid;
  logic [1:0]        o_fill;
  int exp_q[$];
  int win[$];
  int fill_m = 0;
  int last_sum = 0;
  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  sum_of_three #(.DWIDTH(DWIDTH), .IWIDTH(IWIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .i_n(i_n), .i_n_valid(i_n_valid), .i_clear(i_clear),
    .o_sum(o_sum), .o_sum_valid(o_sum_valid), .o_fill(o_fill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a window is the list of samples collected since the last emitted sum
  task automatic step(input bit v, input int n, input bit c);
    @(negedge clk);
    i_n_valid = v;
    i_n = IWIDTH'(n);
    i_clear = c;
    @(posedge clk);
    if (c) win.delete();
    else if (v) begin
      win.push_back(n);
      if (win.size() == 3) begin
        exp_q.push_back(win[0] + win[1] + win[2]);
`ifdef SUM3_SLIDING_EN
        void'(win.pop_front());
`else
        win.delete();
`endif
      end
    end
    fill_m = win.size();
    #1;
    i_n_valid = 1'b0;
    i_clear = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    win.delete();
    fill_m = 0;
    last_sum = 0;
    #1;
    chk("rst_sum", int'(o_sum), 0);
    chk("rst_valid", int'(o_sum_valid), 0);
    chk("rst_fill", int'(o_fill), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (o_sum_valid) begin
        if (exp_q.size() == 0) chk("unexpected_pulse", 1, 0);
        else begin
          last_sum = exp_q.pop_front();
          chk("sum", int'(o_sum), last_sum);
        end
      end else chk("sum_hold", int'(o_sum), last_sum);
      chk("fill", int'(o_fill), fill_m);
    end
  end

  initial begin
    @(negedge clk);
    chk("init_sum", int'(o_sum), 0);
    chk("init_valid", int'(o_sum_valid), 0);
    chk("init_fill", int'(o_fill), 0);
    #2;
    rst_n = 1'b1;
    mon_en = 1'b1;
    step(1, 5, 0); step(1, 7, 0); step(1, 9, 0);
    @(negedge clk); #1;
    chk("sum_5_7_9", int'(o_sum), 21);
    step(1, 63, 0); step(1, 63, 0); step(1, 63, 0);
    @(negedge clk); #1;
    chk("full_scale", int'(o_sum), 189);
    step(1, 1, 1);
    step(1, 1, 0); step(0, 0, 0); step(0, 0, 0); step(1, 2, 0); step(0, 0, 0); step(1, 3, 0);
    step(0, 0, 0); step(0, 0, 0);
    step(1, 4, 0); step(1, 4, 0); step(1, 4, 1); step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
    step(0, 0, 0);
    step(1, 9, 0); step(1, 9, 0);
    do_reset();
    step(1, 2, 0); step(1, 2, 0); step(1, 2, 0);
    @(negedge clk); #1;
    chk("post_reset", int'(o_sum), 6);
    step(1, 1, 1);
    step(1, 1, 0); step(1, 2, 0); step(1, 3, 0); step(1, 4, 0); step(1, 5, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, (1 << IWIDTH) - 1), $urandom_range(0, 19) == 0);
    repeat (3) step(0, 0, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
